mi_arb: RTL and testbench

- Arbitrates the single memory-interface (mi_*) port of the PSRAM QPI controller between N requesters, e.g. memtest plus an LCD frame-fetch DMA.
- Selects one requester, forwards its command, and holds the grant until that burst's data phase completes.
- Sits between requesters and qpi_memctrl in the clk_1x domain.

---
 rtl/arb_rr_pick.sv | 47 ++++
 rtl/mi_arb.sv | 180 ++++++++++++++++++
 tb/tb_mi_arb.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arb_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : arb_rr_pick                                                |
// | Description : Combinational round-robin picker. Scans the request        |
// |               vector starting one position after the last grant and      |
// |               wrapping modulo N; the first asserted request wins.        |
// |               Passing last = N-1 turns it into lowest-index-first        |
// |               priority.                                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Parameters  : N     number of requesters                                 |
// |               IW    index width                                          |
// | Ports       : req   in  [N-1:0]  request vector                          |
// |               last  in  [IW-1:0] index of the previous grant             |
// |               grant out [N-1:0]  one-hot winner (all zero if no request) |
// |               idx   out [IW-1:0] binary winner index (0 if no request)   |
// +--------------------------------------------------------------------------+
module arb_rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic w_found;

    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        // Offsets 1..N visit every index exactly once, ending on 'last'
        // itself, so a lone requester that just won can win again.
        for (int k = 1; k <= N; k++) begin
            automatic logic [IW-1:0] j = IW'((int'(last) + k) % N);
            if (req[j] && !w_found) begin
                w_found  = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mi_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mi_arb                                                     |
// | Description : Arbitrates the single mi_* memory-interface port of the    |
// |               PSRAM QPI controller between N requesters (clk_1x domain). |
// |               One requester is selected in IDLE, its command is passed   |
// |               through in CMD, and the grant is held in DATA until the    |
// |               burst's last beat (wlast/rlast) of the accepted direction. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Build macro : MI_ARB_FIXED_PRIO_EN - when defined, lowest index always   |
// |               wins (no round-robin state; requester 0 can starve others).|
// | Parameters  : N (2..8) requesters, AW address width, LW length width     |
// | Ports       : clk, rst          clock, async active-high reset           |
// |               us_addr/len/rw/valid/wdata  in  flattened, per requester   |
// |               us_ready/wack/wlast/rstb/rlast out  per requester          |
// |               us_rdata          out read data broadcast to all           |
// |               mi_addr/len/rw/valid/wdata  out to controller              |
// |               mi_ready/wack/wlast/rdata/rstb/rlast in from controller    |
// +--------------------------------------------------------------------------+
module mi_arb #(
    parameter int N  = 2,
    parameter int AW = 32,
    parameter int LW = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*AW-1:0] us_addr,
    input  logic [N*LW-1:0] us_len,
    input  logic [N-1:0]    us_rw,
    input  logic [N-1:0]    us_valid,
    output logic [N-1:0]    us_ready,
    input  logic [N*32-1:0] us_wdata,
    output logic [N-1:0]    us_wack,
    output logic [N-1:0]    us_wlast,
    output logic [31:0]     us_rdata,
    output logic [N-1:0]    us_rstb,
    output logic [N-1:0]    us_rlast,
    output logic [AW-1:0]   mi_addr,
    output logic [LW-1:0]   mi_len,
    output logic            mi_rw,
    output logic            mi_valid,
    input  logic            mi_ready,
    output logic [31:0]     mi_wdata,
    input  logic            mi_wack,
    input  logic            mi_wlast,
    input  logic [31:0]     mi_rdata,
    input  logic            mi_rstb,
    input  logic            mi_rlast
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CMD  = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [IW-1:0] r_sel;
    logic          r_dir;        // 1 = read burst in progress
    logic [IW-1:0] w_last;
    logic [N-1:0]  w_win_oh;
    logic [IW-1:0] w_win_idx;
    logic [N-1:0]  w_sel_oh;
    logic          w_any;
    logic          w_sel_valid;
    logic          w_in_cmd;
    logic          w_in_data;
    logic          w_done;

`ifdef MI_ARB_FIXED_PRIO_EN
    // Scanning from N-1+1 = 0 every time gives lowest-index-first priority.
    assign w_last = IW'(N - 1);
`else
    logic [IW-1:0] r_rr_last;
    assign w_last = r_rr_last;
`endif

    arb_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (us_valid),
        .last  (w_last),
        .grant (w_win_oh),
        .idx   (w_win_idx)
    );

    assign w_any       = |w_win_oh;
    assign w_sel_oh    = N'(1) << r_sel;
    assign w_sel_valid = us_valid[r_sel];
    assign w_in_cmd    = (r_state == c_CMD);
    assign w_in_data   = (r_state == c_DATA);

    // Command path: plain muxes of the selected requester.
    assign mi_addr  = us_addr[int'(r_sel)*AW +: AW];
    assign mi_len   = us_len[int'(r_sel)*LW +: LW];
    assign mi_rw    = us_rw[r_sel];
    assign mi_wdata = us_wdata[int'(r_sel)*32 +: 32];
    assign mi_valid = w_in_cmd && w_sel_valid;

    // Strobes reach only the selected requester, and only in the state
    // where they are meaningful; anything the controller drives elsewhere
    // is dropped.
    assign us_ready = {N{w_in_cmd  & mi_ready}} & w_sel_oh;
    assign us_wack  = {N{w_in_data & mi_wack}}  & w_sel_oh;
    assign us_wlast = {N{w_in_data & mi_wlast}} & w_sel_oh;
    assign us_rstb  = {N{w_in_data & mi_rstb}}  & w_sel_oh;
    assign us_rlast = {N{w_in_data & mi_rlast}} & w_sel_oh;
    assign us_rdata = mi_rdata;

    // Completion is decided purely by the last flag of the accepted
    // direction; the beat count is the controller's business.
    assign w_done = w_in_data &&
                    (r_dir ? (mi_rstb && mi_rlast) : (mi_wack && mi_wlast));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_any) begin
                    w_state_nxt = c_CMD;
                end
            end
            c_CMD: begin
                // A requester dropping valid before acceptance abandons
                // the grant without issuing anything.
                if (!w_sel_valid) begin
                    w_state_nxt = c_IDLE;
                end else if (mi_ready) begin
                    w_state_nxt = c_DATA;
                end
            end
            c_DATA: begin
                if (w_done) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel <= '0;
            r_dir <= 1'b0;
        end else begin
            if ((r_state == c_IDLE) && w_any) begin
                r_sel <= w_win_idx;
            end
            if (mi_valid && mi_ready) begin
                r_dir <= mi_rw;
            end
        end
    end

`ifndef MI_ARB_FIXED_PRIO_EN
    // Reset to N-1 so that requester 0 is first in line after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last <= IW'(N - 1);
        end else if ((r_state == c_IDLE) && w_any) begin
            r_rr_last <= w_win_idx;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mi_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mi_arb                                                  |
// | Description : Self-checking bench for mi_arb. A transaction-level model  |
// |               of the arbiter predicts every output each cycle; a simple  |
// |               memory-controller model answers bursts. Directed scenarios |
// |               are followed by a randomized run. Honours                  |
// |               MI_ARB_FIXED_PRIO_EN.                                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mi_arb;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int LW = 7;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N*AW-1:0] us_addr  = '0;
    logic [N*LW-1:0] us_len   = '0;
    logic [N-1:0]    us_rw    = '0;
    logic [N-1:0]    us_valid = '0;
    logic [N-1:0]    us_ready;
    logic [N*32-1:0] us_wdata = '0;
    logic [N-1:0]    us_wack, us_wlast, us_rstb, us_rlast;
    logic [31:0]     us_rdata;
    logic [AW-1:0]   mi_addr;
    logic [LW-1:0]   mi_len;
    logic            mi_rw, mi_valid;
    logic            mi_ready = 1'b0;
    logic [31:0]     mi_wdata;
    logic            mi_wack = 1'b0, mi_wlast = 1'b0;
    logic            mi_rstb = 1'b0, mi_rlast = 1'b0;
    logic [31:0]     mi_rdata = '0;

    always #5 clk = ~clk;

    mi_arb #(.N(N), .AW(AW), .LW(LW)) dut (
        .clk(clk), .rst(rst),
        .us_addr(us_addr), .us_len(us_len), .us_rw(us_rw),
        .us_valid(us_valid), .us_ready(us_ready), .us_wdata(us_wdata),
        .us_wack(us_wack), .us_wlast(us_wlast), .us_rdata(us_rdata),
        .us_rstb(us_rstb), .us_rlast(us_rlast),
        .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw),
        .mi_valid(mi_valid), .mi_ready(mi_ready), .mi_wdata(mi_wdata),
        .mi_wack(mi_wack), .mi_wlast(mi_wlast), .mi_rdata(mi_rdata),
        .mi_rstb(mi_rstb), .mi_rlast(mi_rlast)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // stimulus knobs
    int req_en [N];
    int req_pct, rw_mode, len_fix, len_max, viol_pct, junk_en, rdy_pct, beat_pct;
    logic rst_pulse = 1'b0;

    // observations from the previous cycle, used to drive this one
    logic [N-1:0] hs = '0;
    logic         mhs = 1'b0;
    logic [LW-1:0] c_len;
    logic          c_rw;
    // controller model
    logic c_busy = 1'b0, c_dir = 1'b0;
    int   c_left = 0;

    // arbiter model: phase 0 idle, 1 command offered, 2 data
    int m_phase = 0, m_sel = 0, m_last = N - 1;
    logic m_dir = 1'b0;

    // logs
    int gnt_q[$];
    int n_wack [N];
    int n_rstb [N];
    int rlast_at [N];
    int wl0_cyc, rdy1_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive();
        rst = rst_pulse;
        for (int i = 0; i < N; i++) begin
            logic dropped;
            dropped = 1'b0;
            if (us_valid[i] && hs[i]) begin
                us_valid[i] = 1'b0;
            end else if (us_valid[i] && ($urandom_range(99) < viol_pct)) begin
                us_valid[i] = 1'b0;
                dropped     = 1'b1;
            end
            if (!us_valid[i] && !dropped && req_en[i] != 0 &&
                ($urandom_range(99) < req_pct)) begin
                us_valid[i]          = 1'b1;
                us_addr[i*AW +: AW]  = AW'($urandom);
                us_len[i*LW +: LW]   = (len_fix < 0) ? LW'($urandom_range(len_max)) : LW'(len_fix);
                us_rw[i]             = (rw_mode == 2) ? 1'($urandom) : (rw_mode == 1);
            end
            us_wdata[i*32 +: 32] = $urandom;
        end
        mi_wack  = 1'b0;
        mi_wlast = 1'b0;
        mi_rstb  = 1'b0;
        mi_rlast = 1'b0;
        mi_rdata = $urandom;
        mi_ready = ($urandom_range(99) < rdy_pct);
        if (rst_pulse) begin
            c_busy = 1'b0;
        end else begin
            if (mhs) begin
                c_busy = 1'b1;
                c_left = int'(c_len) + 1;
                c_dir  = c_rw;
            end
            if (c_busy) begin
                if ($urandom_range(99) < beat_pct) begin
                    if (c_dir) mi_rstb = 1'b1; else mi_wack = 1'b1;
                    if (c_left == 1) begin
                        if (c_dir) mi_rlast = 1'b1; else mi_wlast = 1'b1;
                        c_busy = 1'b0;
                    end
                    c_left--;
                end
            end else if (junk_en != 0) begin
                mi_wack  = 1'($urandom);
                mi_wlast = 1'($urandom);
                mi_rstb  = 1'($urandom);
                mi_rlast = 1'($urandom);
            end
        end
    endtask

    task automatic check_cycle();
        logic [N-1:0] oh, z;
        int win;
        z  = '0;
        oh = N'(1) << m_sel;
        if (rst) begin
            chk("rst_mi_valid", mi_valid, 0);
            chk("rst_strobes", {us_ready, us_wack, us_wlast, us_rstb, us_rlast}, 0);
            m_phase = 0; m_sel = 0; m_last = N - 1;
            hs = '0; mhs = 1'b0;
            return;
        end
        chk("mi_valid", mi_valid, (m_phase == 1) && us_valid[m_sel]);
        chk("us_ready", us_ready, (m_phase == 1 && mi_ready) ? oh : z);
        chk("us_wack",  us_wack,  (m_phase == 2 && mi_wack)  ? oh : z);
        chk("us_wlast", us_wlast, (m_phase == 2 && mi_wlast) ? oh : z);
        chk("us_rstb",  us_rstb,  (m_phase == 2 && mi_rstb)  ? oh : z);
        chk("us_rlast", us_rlast, (m_phase == 2 && mi_rlast) ? oh : z);
        chk("mi_addr",  mi_addr,  us_addr[m_sel*AW +: AW]);
        chk("mi_len",   mi_len,   us_len[m_sel*LW +: LW]);
        chk("mi_rw",    mi_rw,    us_rw[m_sel]);
        chk("mi_wdata", mi_wdata, us_wdata[m_sel*32 +: 32]);
        chk("us_rdata", us_rdata, mi_rdata);

        // observations that steer next cycle's stimulus and the logs
        hs    = us_valid & us_ready;
        mhs   = mi_valid & mi_ready;
        c_len = mi_len;
        c_rw  = mi_rw;
        for (int i = 0; i < N; i++) begin
            if (mhs && us_ready[i]) gnt_q.push_back(i);
            if (us_wack[i]) n_wack[i]++;
            if (us_rstb[i]) begin
                n_rstb[i]++;
                if (us_rlast[i]) rlast_at[i] = n_rstb[i];
            end
        end
        if (us_wack[0] && us_wlast[0]) wl0_cyc = cyc;
        if (us_ready[1] && rdy1_cyc < 0) rdy1_cyc = cyc;

        // advance the model to the next cycle
        case (m_phase)
            0: begin
                if (us_valid != 0) begin
                    win = -1;
`ifdef MI_ARB_FIXED_PRIO_EN
                    for (int k = N - 1; k >= 0; k--)
                        if (us_valid[k]) win = k;
`else
                    for (int k = N; k >= 1; k--) begin
                        int j;
                        j = (m_last + k) % N;
                        if (us_valid[j]) win = j;
                    end
                    m_last = win;
`endif
                    m_sel   = win;
                    m_phase = 1;
                end
            end
            1: begin
                if (!us_valid[m_sel]) m_phase = 0;
                else if (mi_ready) begin
                    m_dir   = us_rw[m_sel];
                    m_phase = 2;
                end
            end
            default: begin
                if ((!m_dir && mi_wack && mi_wlast) || (m_dir && mi_rstb && mi_rlast))
                    m_phase = 0;
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        check_cycle();
        cyc++;
    endtask

    task automatic directed_cfg();
        for (int i = 0; i < N; i++) req_en[i] = 0;
        req_pct = 100; rw_mode = 0; len_fix = 0; len_max = 7;
        viol_pct = 0; junk_en = 0; rdy_pct = 100; beat_pct = 100;
    endtask

    task automatic do_reset();
        directed_cfg();
        us_valid  = '0;
        rst_pulse = 1'b1;
        step();
        rst_pulse = 1'b0;
        gnt_q.delete();
        for (int i = 0; i < N; i++) begin
            n_wack[i] = 0; n_rstb[i] = 0; rlast_at[i] = 0;
        end
        wl0_cyc = -1; rdy1_cyc = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, zeros_after, bad;
        directed_cfg();
        do_reset();
        chk("reset_mi_valid", mi_valid, 0);
        chk("reset_ready", us_ready, 0);

        // single read, len=3, requester 0
        rw_mode = 1; len_fix = 3;
        req_en[0] = 1;
        step();
        req_en[0] = 0;
        chk("t1_valid_same_cycle", mi_valid, 0);
        step();
        chk("t1_valid_next_cycle", mi_valid, 1);
        for (int k = 0; k < 20 && rlast_at[0] == 0; k++) step();
        chk("t1_rstb_count", n_rstb[0], 4);
        chk("t1_rlast_on_beat", rlast_at[0], 4);

        // simultaneous writes, len=1
        do_reset();
        rw_mode = 0; len_fix = 1;
        req_en[0] = 1; req_en[1] = 1;
        step();
        req_en[0] = 0; req_en[1] = 0;
        for (int k = 0; k < 40 && n_wack[1] < 2; k++) step();
        chk("t2_grants", gnt_q.size(), 2);
        chk("t2_first", (gnt_q.size() > 0) ? gnt_q[0] : 99, 0);
        chk("t2_second", (gnt_q.size() > 1) ? gnt_q[1] : 99, 1);
        chk("t2_gap_wlast_to_valid", rdy1_cyc - wl0_cyc, 2);

        // continuous requests from 0 and 1
        do_reset();
        rw_mode = 0; len_fix = 0;
        req_en[0] = 1; req_en[1] = 1;
`ifdef MI_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 60 && gnt_q.size() < 4; k++) step();
        for (int g = 0; g < 4; g++)
            chk("fp_grant_zero", (gnt_q.size() > g) ? gnt_q[g] : 99, 0);
        s0 = gnt_q.size();
        req_en[0] = 0;
        for (int k = 0; k < 60 && !(gnt_q.size() > s0 && gnt_q[$] == 1); k++) step();
        chk("fp_grant_one", (gnt_q.size() > s0) ? gnt_q[$] : 99, 1);
        zeros_after = 0;
        for (int g = s0; g < gnt_q.size(); g++) if (gnt_q[g] == 0) zeros_after++;
        chk("fp_zero_drain", zeros_after <= 1, 1);
        chk("fp_req0_low", us_valid[0], 0);
`else
        for (int k = 0; k < 100 && gnt_q.size() < 6; k++) step();
        for (int g = 0; g < 6; g++)
            chk("rr_grant_order", (gnt_q.size() > g) ? gnt_q[g] : 99, g % 2);
`endif
        req_en[0] = 0; req_en[1] = 0;

        // requester 1 arrives during requester 0's long read
        do_reset();
        rw_mode = 1; len_fix = 127;
        req_en[0] = 1;
        for (int k = 0; k < 10 && gnt_q.size() < 1; k++) begin
            step();
            req_en[0] = 0;
        end
        req_en[1] = 1; len_fix = 0;
        bad = 0;
        for (int k = 0; k < 300 && rlast_at[0] == 0; k++) begin
            step();
            req_en[1] = 0;
            if (us_ready[1] || mi_valid) bad++;
        end
        chk("t4_rlast_seen", rlast_at[0], 128);
        chk("t4_hold_off", bad, 0);
        for (int k = 0; k < 10 && gnt_q.size() < 2; k++) step();
        chk("t4_then_req1", (gnt_q.size() > 1) ? gnt_q[1] : 99, 1);

        // reset on the 2nd beat of a 4-beat write
        do_reset();
        rw_mode = 0; len_fix = 3;
        req_en[0] = 1;
        step();
        req_en[0] = 0;
        for (int k = 0; k < 20 && n_wack[0] < 1; k++) step();
        chk("t5_first_beat", n_wack[0], 1);
        rst_pulse = 1'b1;
        step();
        rst_pulse = 1'b0;
        chk("t5_wack_cleared", us_wack, 0);
        chk("t5_valid_cleared", mi_valid, 0);
        gnt_q.delete();
        len_fix = 0;
        req_en[0] = 1; req_en[1] = 1;
        for (int k = 0; k < 20 && gnt_q.size() < 1; k++) step();
        chk("t5_first_after_reset", (gnt_q.size() > 0) ? gnt_q[0] : 99, 0);

        // randomized traffic with junk strobes, violations and resets
        do_reset();
        for (int i = 0; i < N; i++) req_en[i] = 1;
        req_pct = 30; rw_mode = 2; len_fix = -1; len_max = 7;
        viol_pct = 3; junk_en = 1; rdy_pct = 60; beat_pct = 70;
        for (int k = 0; k < 3000; k++) begin
            rst_pulse = ($urandom_range(499) == 0);
            step();
        end
        rst_pulse = 1'b0;
        chk("rand_grants_made", gnt_q.size() > 20, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
